// File: rtl/ir_nec_decoder.sv
// NEC infrared frame decoder: synchronised input, one edge-to-edge duration counter, six-state frame FSM.
// Define IR_INV_CHECK_EN to reject data frames whose complement bytes do not match; TIME_DIV scales every threshold down.
module ir_nec_decoder #(
  parameter int unsigned TIME_DIV = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       infrared_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       data_valid,
  output logic       repeat_en
);

`ifdef IR_INV_CHECK_EN
  localparam bit INV_CHECK = 1'b1;
`else
  localparam bit INV_CHECK = 1'b0;
`endif

  // Durations in sys_clk cycles (20 ns each at TIME_DIV = 1).
  localparam logic [19:0] LEAD_LO_MIN = 20'(400_000 / TIME_DIV);
  localparam logic [19:0] LEAD_LO_MAX = 20'(500_000 / TIME_DIV);
  localparam logic [19:0] LEAD_HI_MIN = 20'(200_000 / TIME_DIV);
  localparam logic [19:0] LEAD_HI_MAX = 20'(250_000 / TIME_DIV);
  localparam logic [19:0] RPT_HI_MIN  = 20'(100_000 / TIME_DIV);
  localparam logic [19:0] RPT_HI_MAX  = 20'(125_000 / TIME_DIV);
  localparam logic [19:0] SHORT_MIN   = 20'(20_000 / TIME_DIV);
  localparam logic [19:0] SHORT_MAX   = 20'(35_000 / TIME_DIV);
  localparam logic [19:0] ONE_MIN     = 20'(75_000 / TIME_DIV);
  localparam logic [19:0] ONE_MAX     = 20'(90_000 / TIME_DIV);
  localparam logic [19:0] TIMEOUT     = 20'(550_000 / TIME_DIV);

  typedef enum logic [2:0] {IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP} state_t;

  logic        sync1_q, sync2_q, prev_q;
  logic [19:0] cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [31:0] shift_q, shift_d;
  logic        rpt_q, rpt_d;
  logic        seen_q, seen_d;
  logic [7:0]  addr_q, addr_d, cmd_q, cmd_d;
  logic        dv_q, dv_d, rep_q, rep_d;
  logic        fall_edge, rise_edge, inv_ok;
  logic        is_short, is_one;

  function automatic logic in_range(input logic [19:0] v, input logic [19:0] lo, input logic [19:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign fall_edge = prev_q & ~sync2_q;
  assign rise_edge = ~prev_q & sync2_q;
  assign is_short  = in_range(cnt_q, SHORT_MIN, SHORT_MAX);
  assign is_one    = in_range(cnt_q, ONE_MIN, ONE_MAX);
  assign inv_ok    = !INV_CHECK ||
                     ((shift_q[15:8] == ~shift_q[7:0]) && (shift_q[31:24] == ~shift_q[23:16]));

  assign cnt_d = (fall_edge | rise_edge) ? 20'd0 :
                 (cnt_q == 20'hFFFFF)    ? cnt_q : cnt_q + 20'd1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      cnt_q     <= 20'd0;
      state_q   <= IDLE;
      bit_idx_q <= 5'd0;
      shift_q   <= 32'd0;
      rpt_q     <= 1'b0;
      seen_q    <= 1'b0;
      addr_q    <= 8'd0;
      cmd_q     <= 8'd0;
      dv_q      <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      sync1_q   <= infrared_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rpt_q     <= rpt_d;
      seen_q    <= seen_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      dv_q      <= dv_d;
      rep_q     <= rep_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rpt_d     = rpt_q;
    seen_d    = seen_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    dv_d      = 1'b0;
    rep_d     = 1'b0;
    // A stuck level anywhere inside a frame abandons it.
    if (state_q != IDLE && cnt_q >= TIMEOUT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (fall_edge) begin
          state_d   = LEAD_LOW;
          bit_idx_d = 5'd0;
          shift_d   = 32'd0;
          rpt_d     = 1'b0;
        end
        LEAD_LOW: if (rise_edge) begin
          state_d = in_range(cnt_q, LEAD_LO_MIN, LEAD_LO_MAX) ? LEAD_HIGH : IDLE;
        end
        LEAD_HIGH: if (fall_edge) begin
          if (in_range(cnt_q, LEAD_HI_MIN, LEAD_HI_MAX)) begin
            state_d   = BIT_LOW;
            bit_idx_d = 5'd0;
          end else if (in_range(cnt_q, RPT_HI_MIN, RPT_HI_MAX)) begin
            state_d = STOP;
            rpt_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        BIT_LOW: if (rise_edge) begin
          state_d = is_short ? BIT_HIGH : IDLE;
        end
        BIT_HIGH: if (fall_edge) begin
          if (is_short || is_one) begin
            shift_d = {is_one, shift_q[31:1]};
            if (bit_idx_q == 5'd31) begin
              state_d = STOP;
              rpt_d   = 1'b0;
            end else begin
              bit_idx_d = bit_idx_q + 5'd1;
              state_d   = BIT_LOW;
            end
          end else begin
            state_d = IDLE;
          end
        end
        STOP: if (rise_edge) begin
          state_d = IDLE;
          if (is_short) begin
            if (rpt_q) begin
              rep_d = seen_q;
            end else if (inv_ok) begin
              addr_d = shift_q[7:0];
              cmd_d  = shift_q[23:16];
              dv_d   = 1'b1;
              seen_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign addr       = addr_q;
  assign cmd        = cmd_q;
  assign data_valid = dv_q;
  assign repeat_en  = rep_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Directed NEC-frame bench with a frame-level model and a per-cycle output monitor.
// Thresholds are scaled by TIME_DIV = 1000, so 1 ms of IR time is 50 cycles.
module tb_ir_nec_decoder;
  localparam int DIV       = 1000;
  localparam int T_LEAD_LO = 450;   // 9 ms
  localparam int T_LEAD_HI = 225;   // 4.5 ms
  localparam int T_RPT_HI  = 112;   // 2.24 ms
  localparam int T_BURST   = 28;    // 560 us
  localparam int T_ZERO    = 28;    // 560 us
  localparam int T_ONE     = 84;    // 1.68 ms
  localparam int T_BAD     = 60;    // 1.2 ms, neither 0 nor 1
  localparam int T_TAIL    = 20;

`ifdef IR_INV_CHECK_EN
  localparam bit INV_CHECK = 1'b1;
`else
  localparam bit INV_CHECK = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       infrared_in = 1'b1;
  logic [7:0] addr, cmd;
  logic       data_valid, repeat_en;

  ir_nec_decoder #(.TIME_DIV(DIV)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .infrared_in(infrared_in),
    .addr       (addr),
    .cmd        (cmd),
    .data_valid (data_valid),
    .repeat_en  (repeat_en)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  // Model state: what the outputs hold now, and what the running transaction must produce.
  logic [7:0] cur_addr = 8'h00, cur_cmd = 8'h00;
  logic [7:0] exp_addr = 8'h00, exp_cmd = 8'h00;
  bit         frame_seen = 1'b0;
  bit         exp_dv = 1'b0, exp_rep = 1'b0;
  int         dv_cnt = 0, rep_cnt = 0;
  logic       dv_prev = 1'b0, rep_prev = 1'b0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic bit accept(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
    return !INV_CHECK || ((b1 == ~b0) && (b3 == ~b2));
  endfunction

  always @(posedge sys_clk) begin
    #1;
    if (mon_en) begin
      check("dv_rep_overlap", 32'(data_valid & repeat_en), 32'd0);
      check("dv_width", 32'(data_valid & dv_prev), 32'd0);
      check("rep_width", 32'(repeat_en & rep_prev), 32'd0);
      if (data_valid) dv_cnt++;
      if (repeat_en) rep_cnt++;
      check("addr_track", 32'(addr), 32'((dv_cnt > 0) ? exp_addr : cur_addr));
      check("cmd_track", 32'(cmd), 32'((dv_cnt > 0) ? exp_cmd : cur_cmd));
      dv_prev  = data_valid;
      rep_prev = repeat_en;
    end
  end

  initial begin
    repeat (90000) @(posedge sys_clk);
    $display("FAIL watchdog: run exceeded 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic level(input logic v, input int n);
    infrared_in = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      level(1'b0, T_BURST);
      level(1'b1, w[i] ? T_ONE : T_ZERO);
    end
  endtask

  task automatic begin_txn(input bit dv, input bit rep, input logic [7:0] a, input logic [7:0] c);
    exp_dv   = dv;
    exp_rep  = rep;
    exp_addr = dv ? a : cur_addr;
    exp_cmd  = dv ? c : cur_cmd;
    dv_cnt   = 0;
    rep_cnt  = 0;
  endtask

  task automatic end_txn(input string name);
    check({name, "_dv_pulses"}, 32'(dv_cnt), 32'(exp_dv));
    check({name, "_rep_pulses"}, 32'(rep_cnt), 32'(exp_rep));
    if (exp_dv) begin
      cur_addr   = exp_addr;
      cur_cmd    = exp_cmd;
      frame_seen = 1'b1;
    end
    $display("txn %s: dv=%0d rep=%0d addr=%02h cmd=%02h", name, dv_cnt, rep_cnt, addr, cmd);
  endtask

  task automatic data_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int lead_lo, input int bad_bit);
    logic [31:0] w;
    real         lead_ms;
    bit          timing_ok;
    w         = {b3, b2, b1, b0};
    lead_ms   = real'(lead_lo) * 20.0 * real'(DIV) / 1.0e6;
    timing_ok = (lead_ms >= 8.0) && (lead_ms <= 10.0) && (bad_bit < 0);
    begin_txn(timing_ok && accept(b0, b1, b2, b3), 1'b0, b0, b2);
    level(1'b0, lead_lo);
    level(1'b1, T_LEAD_HI);
    for (int i = 0; i < 32; i++) begin
      level(1'b0, T_BURST);
      level(1'b1, (i == bad_bit) ? T_BAD : (w[i] ? T_ONE : T_ZERO));
    end
    level(1'b0, T_BURST);
    level(1'b1, T_TAIL);
    end_txn(name);
  endtask

  task automatic repeat_frame(input string name);
    begin_txn(1'b0, frame_seen, 8'h00, 8'h00);
    level(1'b0, T_LEAD_LO);
    level(1'b1, T_RPT_HI);
    level(1'b0, T_BURST);
    level(1'b1, T_TAIL);
    end_txn(name);
  endtask

  task automatic assert_reset(input int n);
    sys_rst_n  = 1'b0;
    cur_addr   = 8'h00;
    cur_cmd    = 8'h00;
    exp_addr   = 8'h00;
    exp_cmd    = 8'h00;
    frame_seen = 1'b0;
    @(posedge sys_clk);
    #1;
    check("rst_addr", 32'(addr), 32'h00);
    check("rst_cmd", 32'(cmd), 32'h00);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_rep", 32'(repeat_en), 32'd0);
    repeat (n) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    @(negedge sys_clk);
    assert_reset(4);
    mon_en = 1'b1;
    level(1'b1, 10);

    repeat_frame("repeat_no_prior_frame");

    data_frame("frame_00_45", 8'h00, 8'hFF, 8'h45, 8'hBA, T_LEAD_LO, -1);
    check("lit_026_addr", 32'(addr), 32'h00);
    check("lit_026_cmd", 32'(cmd), 32'h45);

    level(1'b1, 2000);
    repeat_frame("repeat_after_frame");
    check("lit_027_rep_count", 32'(rep_cnt), 32'd1);
    check("lit_027_cmd", 32'(cmd), 32'h45);

    data_frame("frame_bad_inverse", 8'h10, 8'hEF, 8'h22, 8'hDE, T_LEAD_LO, -1);
    check("lit_029_cmd", 32'(cmd), INV_CHECK ? 32'h45 : 32'h22);
    check("lit_029_addr", 32'(addr), INV_CHECK ? 32'h00 : 32'h10);

    data_frame("lead_7p8ms", 8'h5A, 8'hA5, 8'h3C, 8'hC3, 390, -1);
    data_frame("lead_10p5ms", 8'h5A, 8'hA5, 8'h3C, 8'hC3, 525, -1);
    data_frame("lead_8p1ms", 8'h5A, 8'hA5, 8'h3C, 8'hC3, 405, -1);
    check("lit_lead_ok_cmd", 32'(cmd), 32'h3C);

    data_frame("bad_space_bit9", 8'h33, 8'hCC, 8'h77, 8'h88, T_LEAD_LO, 9);

    w = {8'h0F, 8'hF0, 8'h55, 8'hAA};
    begin_txn(1'b0, 1'b0, 8'h00, 8'h00);
    level(1'b0, T_LEAD_LO);
    level(1'b1, T_LEAD_HI);
    send_bits(w, 0, 15);
    level(1'b0, T_BURST);
    level(1'b1, 750);
    end_txn("truncated_bit15");
    data_frame("frame_after_trunc", 8'h01, 8'hFE, 8'h0C, 8'hF3, T_LEAD_LO, -1);
    check("lit_030_cmd", 32'(cmd), 32'h0C);

    w = {8'h3F, 8'hC0, 8'h7E, 8'h81};
    begin_txn(1'b0, 1'b0, 8'h00, 8'h00);
    level(1'b0, T_LEAD_LO);
    level(1'b1, T_LEAD_HI);
    send_bits(w, 0, 20);
    level(1'b0, 10);
    assert_reset(4);
    level(1'b0, 14);
    level(1'b1, w[20] ? T_ONE : T_ZERO);
    send_bits(w, 21, 32);
    level(1'b0, T_BURST);
    level(1'b1, T_TAIL);
    end_txn("reset_at_bit20");
    check("lit_031_addr", 32'(addr), 32'h00);
    check("lit_031_cmd", 32'(cmd), 32'h00);

    repeat_frame("repeat_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_nec_decoder.md
IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 SHALL have port sys_clk  input  1  system clock, 50 MHz (20 ns period), all logic on its rising edge.
REQ-002 SHALL have port sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port infrared_in  input  1  raw output of the IR receiver, idle high, active-low carrier bursts, asynchronous to sys_clk.
REQ-004 SHALL have port addr  output  8  address byte of the last accepted frame.
REQ-005 SHALL have port cmd  output  8  command byte of the last accepted frame.
REQ-006 SHALL have port data_valid  output  1  one-cycle pulse when addr/cmd update.
REQ-007 SHALL have port repeat_en  output  1  one-cycle pulse per accepted NEC repeat code; feeds led_ctrl.

Function
REQ-008 SHALL pass infrared_in through a 2-flop synchronizer, then a third flop for edge detection; all timing uses the synchronized level.
REQ-009 SHALL run one 20-bit duration counter, cleared on every input edge, incrementing otherwise, saturating at 2^20-1.
REQ-010 SHALL use states IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP; fall edge in IDLE -> LEAD_LOW.
REQ-011 LEAD_LOW: rise edge with count in [400_000, 500_000] (8–10 ms) -> LEAD_HIGH, else -> IDLE.
REQ-012 LEAD_HIGH: fall edge with count in [200_000, 250_000] (4–5 ms) -> BIT_LOW with bit index 0; in [100_000, 125_000] (2–2.5 ms) -> STOP with repeat flag set; otherwise -> IDLE.
REQ-013 BIT_LOW: rise edge with count in [20_000, 35_000] (0.4–0.7 ms) -> BIT_HIGH, else -> IDLE.
REQ-014 BIT_HIGH: fall edge with count in [20_000, 35_000] stores 0, in [75_000, 90_000] (1.5–1.8 ms) stores 1, else -> IDLE; bits shift in LSB first into a 32-bit register.
REQ-015 After storing bit index 31 SHALL go to STOP with repeat flag clear; otherwise bit index +1 and -> BIT_LOW.
REQ-016 STOP: rise edge with count in [20_000, 35_000] ends the frame; other count -> IDLE with no output.
REQ-017 Data frame end: byte0 = address, byte1 = ~address, byte2 = command, byte3 = ~command; on acceptance addr/cmd load on the same edge that data_valid is high, and the "frame seen" flag sets.
REQ-018 Repeat frame end: repeat_en pulses one cycle only if "frame seen" is set; addr/cmd unchanged.
REQ-019 Any state except IDLE with count reaching 550_000 (11 ms) SHALL return to IDLE, discarding partial data.
REQ-020 data_valid and repeat_en SHALL never be high in the same cycle and never for more than one cycle; latency is 1 cycle after the STOP rise edge is detected.
REQ-021 addr/cmd SHALL hold their value across rejected, aborted and repeat frames.

Reset
REQ-022 On sys_rst_n low: state IDLE, counter 0, bit index 0, shift register 0, synchronizer flops 1, addr 0, cmd 0, data_valid 0, repeat_en 0, frame-seen flag 0.
REQ-023 Reset mid-frame SHALL discard the frame; after release, decoding restarts only on a new falling edge from idle-high.

Configuration
REQ-024 Macro IR_INV_CHECK_EN defined: data frame accepted only if byte1 == ~byte0 and byte3 == ~byte2, else -> IDLE with no pulse and frame-seen unchanged.
REQ-025 Macro IR_INV_CHECK_EN undefined: complement bytes ignored, every well-timed data frame accepted.

Verification
REQ-026 Reset released, NEC frame addr 0x00 cmd 0x45 (inverses correct) -> one data_valid pulse, addr = 0x00, cmd = 0x45, repeat_en stays 0.
REQ-027 Valid frame, then 40 ms later repeat code (9 ms low, 2.25 ms high, 560 us burst) -> exactly one repeat_en pulse, addr/cmd unchanged, no data_valid.
REQ-028 Repeat code immediately after reset with no prior frame -> no repeat_en, no data_valid.
REQ-029 Frame addr 0x10 cmd 0x22 with byte3 = 0xDE (bad inverse) -> with IR_INV_CHECK_EN no pulse, outputs hold previous values; without it data_valid, cmd = 0x22.
REQ-030 Frame truncated after bit 15, line held high 15 ms -> IDLE by 11 ms, no pulse; following good frame cmd 0x0C decoded correctly.
REQ-031 sys_rst_n pulsed low during bit 20 of a frame -> addr, cmd, outputs 0; remainder of that frame produces no pulse.
